nco_ctrl: RTL and testbench

Sequencer for the sine/cosine NCO. It fills the 512-entry dual-port sin/cos table through SRAM write port 0 from a valid/ready load stream, then preloads the phase counter. It then opens table read port 1 and runs the counter. While running it can optionally sweep the phase increment `delta` in timed steps. It sits between the host/loader logic and the existing `counter` block, and drives every control input of that block.

---
 rtl/nco_pkg.sv | 19 +
 rtl/nco_ctrl_if.sv | 21 ++
 rtl/nco_sweep.sv | 50 +++++
 rtl/nco_ctrl.sv | 178 +++++++++++++++++
 tb/tb_nco_ctrl.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nco_pkg.sv
// -----------------------------------------------------------------------------
// nco_pkg
// Shared definitions for the NCO sequencer: the sequencer state encoding and
// the table / write-mask constants used by nco_ctrl.
// -----------------------------------------------------------------------------
package nco_pkg;

  // Sequencer states: fill the table, preload the counter for one cycle, run.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PRIME = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam int         TABLE_DEPTH = 512;
  localparam logic [3:0] WMASK_ALL   = 4'hF;

endpackage

// File: rtl/nco_ctrl_if.sv
// -----------------------------------------------------------------------------
// nco_ctrl_if
// Valid/ready load stream carrying one sin/cos table entry per transfer, in
// ascending address order.
//   load_valid : source has an entry on load_sin/load_cos
//   load_ready : sequencer accepts an entry this cycle
//   load_sin   : sine word for the next table address
//   load_cos   : cosine word for the next table address
// master = loader side, slave = nco_ctrl side.
// -----------------------------------------------------------------------------
interface nco_ctrl_if #(
  parameter int DW = 32
);
  logic          load_valid;
  logic          load_ready;
  logic [DW-1:0] load_sin;
  logic [DW-1:0] load_cos;

  modport master (output load_valid, output load_sin, output load_cos, input load_ready);
  modport slave  (input load_valid, input load_sin, input load_cos, output load_ready);
endinterface

// File: rtl/nco_sweep.sv
// -----------------------------------------------------------------------------
// nco_sweep
// Dwell counter plus phase-increment stepper. While enabled, every 'dwell'
// cycles delta advances by one, wrapping back to delta_start once it has
// reached delta_max.
//   clk, reset  : clock, asynchronous active-low reset
//   load        : restart the sweep at delta_start with a cleared dwell count
//   enable      : count this cycle toward the next step
//   delta_start : first / wrap-to value
//   delta_max   : value at or above which the next step wraps
//   dwell       : cycles per step (caller keeps enable low when zero)
//   delta       : current phase increment
// -----------------------------------------------------------------------------
module nco_sweep #(
  parameter int DELTA_W = 4,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               enable,
  input  logic [DELTA_W-1:0] delta_start,
  input  logic [DELTA_W-1:0] delta_max,
  input  logic [DWELL_W-1:0] dwell,
  output logic [DELTA_W-1:0] delta
);

  logic [DWELL_W-1:0] dwell_cnt;
  logic               step;

  // The step fires on the last cycle of a dwell period, so the new delta is
  // visible exactly 'dwell' cycles after the previous change.
  assign step = enable && (dwell_cnt == dwell - 1'b1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_cnt <= '0;
      delta     <= '0;
    end else if (load) begin
      dwell_cnt <= '0;
      delta     <= delta_start;
    end else if (step) begin
      dwell_cnt <= '0;
      delta     <= (delta >= delta_max) ? delta_start : delta + 1'b1;
    end else if (enable) begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nco_ctrl.sv
// -----------------------------------------------------------------------------
// nco_ctrl
// Sequencer for the sine/cosine NCO. Fills the dual-port sin/cos table through
// SRAM port 0 from the load stream, preloads the phase counter for one cycle,
// then enables table read port 1 and runs the counter, optionally sweeping the
// phase increment.
//   clk, reset            : clock, asynchronous active-low reset
//   start, stop           : one-cycle control pulses (stop has priority)
//   load                  : load stream (slave side)
//   phase0, dir           : counter preload value / direction, sampled at start
//   delta_start/max       : sweep bounds, sampled at start
//   sweep_en, dwell       : sweep enable and cycles per step, sampled at start
//   csb0..din01           : SRAM port 0 write controls (active-low enables)
//   csb1                  : SRAM port 1 read enable (active-low)
//   preload..delta        : counter controls
//   busy, running         : status (LOAD/PRIME, RUN)
// -----------------------------------------------------------------------------
module nco_ctrl
  import nco_pkg::*;
#(
  parameter int AW      = 9,
  parameter int DW      = 32,
  parameter int DELTA_W = 4,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  nco_ctrl_if.slave          load,
  input  logic [AW-1:0]      phase0,
  input  logic               dir,
  input  logic [DELTA_W-1:0] delta_start,
  input  logic [DELTA_W-1:0] delta_max,
  input  logic               sweep_en,
  input  logic [DWELL_W-1:0] dwell,
  output logic               csb0,
  output logic               web0,
  output logic [3:0]         wmask0,
  output logic [AW-1:0]      addr0,
  output logic [DW-1:0]      din00,
  output logic [DW-1:0]      din01,
  output logic               csb1,
  output logic               preload,
  output logic [AW-1:0]      pl_data,
  output logic               up_dn,
  output logic [DELTA_W-1:0] delta,
  output logic               busy,
  output logic               running
);

  state_t               state;
  state_t               state_next;
  logic [AW-1:0]        addr_cnt;
  logic [AW-1:0]        phase0_q;
  logic                 dir_q;
  logic [DELTA_W-1:0]   delta_start_q;
  logic [DELTA_W-1:0]   delta_max_q;
  logic                 sweep_en_q;
  logic [DWELL_W-1:0]   dwell_q;
  logic                 launch;
  logic                 write_go;
  logic                 last_write;

  assign load.load_ready = (state == LOAD);
  assign launch          = (state == IDLE) && start && !stop;
  // A transfer in the same cycle as stop is dropped: stop wins.
  assign write_go        = load.load_valid && load.load_ready && !stop;
  assign last_write      = write_go && (addr_cnt == AW'(TABLE_DEPTH - 1));
  assign busy            = (state == LOAD) || (state == PRIME);
  assign running         = (state == RUN);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; stop returns to IDLE from anywhere.
  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = LOAD;
        LOAD:    if (last_write) state_next = PRIME;
        PRIME:   state_next = RUN;
        RUN:     state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Configuration snapshot at start, and the table fill address. The address
  // counter wraps by itself after entry 511, which is also where LOAD ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_cnt      <= '0;
      phase0_q      <= '0;
      dir_q         <= 1'b1;
      delta_start_q <= '0;
      delta_max_q   <= '0;
      sweep_en_q    <= 1'b0;
      dwell_q       <= '0;
    end else if (launch) begin
      addr_cnt      <= '0;
      phase0_q      <= phase0;
      dir_q         <= dir;
      delta_start_q <= delta_start;
      delta_max_q   <= delta_max;
      sweep_en_q    <= sweep_en;
      dwell_q       <= dwell;
    end else if (write_go) begin
      addr_cnt      <= addr_cnt + 1'b1;
    end
  end

  // Port 0: one registered write per accepted transfer. Idle cycles only
  // deselect the port; address and data hold their last values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csb0   <= 1'b1;
      web0   <= 1'b1;
      wmask0 <= '0;
      addr0  <= '0;
      din00  <= '0;
      din01  <= '0;
    end else if (write_go) begin
      csb0   <= 1'b0;
      web0   <= 1'b0;
      wmask0 <= WMASK_ALL;
      addr0  <= addr_cnt;
      din00  <= load.load_sin;
      din01  <= load.load_cos;
    end else begin
      csb0   <= 1'b1;
      web0   <= 1'b1;
    end
  end

  // Counter controls follow the upcoming state so that preload is high
  // exactly during PRIME and the read port is enabled exactly during RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csb1    <= 1'b1;
      preload <= 1'b0;
      pl_data <= '0;
      up_dn   <= 1'b1;
    end else begin
      csb1    <= (state_next != RUN);
      preload <= (state_next == PRIME);
      if (state_next == PRIME) begin
        pl_data <= phase0_q;
        up_dn   <= dir_q;
      end
    end
  end

  // Sweep restarts as the counter is primed; a zero dwell disables stepping.
  nco_sweep #(
    .DELTA_W (DELTA_W),
    .DWELL_W (DWELL_W)
  ) u_sweep (
    .clk         (clk),
    .reset       (reset),
    .load        (state_next == PRIME),
    .enable      ((state == RUN) && !stop && sweep_en_q && (dwell_q != '0)),
    .delta_start (delta_start_q),
    .delta_max   (delta_max_q),
    .dwell       (dwell_q),
    .delta       (delta)
  );

endmodule

// File: tb/tb_nco_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nco_ctrl
// Self-checking bench for nco_ctrl: random table contents and configurations,
// expected writes, preload timing and delta sweep computed from the sequencer
// rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_nco_ctrl;

  localparam int AW          = 9;
  localparam int DW          = 32;
  localparam int DELTA_W     = 4;
  localparam int DWELL_W     = 16;
  localparam int TABLE_DEPTH = 512;
  localparam int RV_W        = 2 + 4 + AW + DW + DW + 1 + 1 + AW + 1 + DELTA_W + 3;
  localparam logic [RV_W-1:0] RESET_VEC = {2'b11, 4'h0, {AW{1'b0}}, {DW{1'b0}}, {DW{1'b0}},
                                           1'b1, 1'b0, {AW{1'b0}}, 1'b1, {DELTA_W{1'b0}}, 3'b000};

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               stop;
  logic [AW-1:0]      phase0;
  logic               dir;
  logic [DELTA_W-1:0] delta_start;
  logic [DELTA_W-1:0] delta_max;
  logic               sweep_en;
  logic [DWELL_W-1:0] dwell;
  logic               csb0;
  logic               web0;
  logic [3:0]         wmask0;
  logic [AW-1:0]      addr0;
  logic [DW-1:0]      din00;
  logic [DW-1:0]      din01;
  logic               csb1;
  logic               preload;
  logic [AW-1:0]      pl_data;
  logic               up_dn;
  logic [DELTA_W-1:0] delta;
  logic               busy;
  logic               running;

  nco_ctrl_if #(.DW(DW)) lif ();

  nco_ctrl #(
    .AW(AW), .DW(DW), .DELTA_W(DELTA_W), .DWELL_W(DWELL_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .load(lif),
    .phase0(phase0), .dir(dir), .delta_start(delta_start), .delta_max(delta_max),
    .sweep_en(sweep_en), .dwell(dwell),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din00(din00), .din01(din01),
    .csb1(csb1), .preload(preload), .pl_data(pl_data), .up_dn(up_dn), .delta(delta),
    .busy(busy), .running(running)
  );

  always #5 clk = ~clk;

  // Posedge counter: a sample taken at a negedge shows the result of edge 'cyc'.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sin_tab [TABLE_DEPTH];
  logic [DW-1:0] cos_tab [TABLE_DEPTH];

  // Configuration applied at the next start (the reference for all checks).
  logic [AW-1:0]      cfg_phase0;
  logic               cfg_dir;
  logic [DELTA_W-1:0] cfg_dstart;
  logic [DELTA_W-1:0] cfg_dmax;
  logic               cfg_sweep;
  logic [DWELL_W-1:0] cfg_dwell;

  // Observation log.
  int            xfer_edges [$];
  int            wr_cyc     [$];
  logic [AW-1:0] wr_addr    [$];
  logic [DW-1:0] wr_sin     [$];
  logic [DW-1:0] wr_cos     [$];
  logic [3:0]    wr_mask    [$];
  int            pre_cyc    [$];
  logic [AW-1:0] pre_data   [$];
  logic          pre_updn   [$];
  logic [DELTA_W-1:0] pre_delta [$];
  int            csb1_low_cyc;
  int            run_edge;

  // Watchdog so the run always terminates.
  initial begin
    #(2000000);
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [DELTA_W-1:0] exp_delta(input int k);
    int s, m, d, n;
    s = int'(cfg_dstart);
    m = int'(cfg_dmax);
    d = int'(cfg_dwell);
    if (!cfg_sweep || d == 0 || s >= m) return cfg_dstart;
    n = k / d;
    return DELTA_W'(s + n % (m - s + 1));
  endfunction

  function automatic int last_edge();
    if (xfer_edges.size() > 0) return xfer_edges[$];
    return -1000;
  endfunction

  task automatic fill_tables();
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      sin_tab[i] = $urandom;
      cos_tab[i] = $urandom;
    end
  endtask

  task automatic clear_log();
    xfer_edges.delete(); wr_cyc.delete(); wr_addr.delete(); wr_sin.delete();
    wr_cos.delete(); wr_mask.delete(); pre_cyc.delete(); pre_data.delete();
    pre_updn.delete(); pre_delta.delete();
    csb1_low_cyc = -1;
  endtask

  task automatic sample_cycle();
    if (!csb0 && !web0) begin
      wr_cyc.push_back(cyc); wr_addr.push_back(addr0); wr_sin.push_back(din00);
      wr_cos.push_back(din01); wr_mask.push_back(wmask0);
    end
    if (preload) begin
      pre_cyc.push_back(cyc); pre_data.push_back(pl_data);
      pre_updn.push_back(up_dn); pre_delta.push_back(delta);
    end
    if (!csb1 && csb1_low_cyc < 0) csb1_low_cyc = cyc;
  endtask

  task automatic do_start();
    clear_log();
    @(negedge clk); sample_cycle();
    start = 1'b1; phase0 = cfg_phase0; dir = cfg_dir; delta_start = cfg_dstart;
    delta_max = cfg_dmax; sweep_en = cfg_sweep; dwell = cfg_dwell;
    @(negedge clk); sample_cycle();
    start = 1'b0; phase0 = ~cfg_phase0; dir = ~cfg_dir; delta_start = DELTA_W'($urandom);
    delta_max = DELTA_W'($urandom); sweep_en = ~cfg_sweep; dwell = DWELL_W'($urandom);
  endtask

  task automatic do_stop();
    @(negedge clk); sample_cycle();
    stop = 1'b1; lif.load_valid = 1'b0;
    @(negedge clk); sample_cycle();
    stop = 1'b0;
  endtask

  // Streams the table; with stop_idx >= 0 it raises stop instead of sending that entry.
  task automatic run_load(input bit throttle, input int stop_idx);
    int idx = 0;
    int guard = 0;
    bit v;
    while (idx < TABLE_DEPTH && guard < 4000) begin
      @(negedge clk); sample_cycle(); guard++;
      v = throttle ? bit'($urandom_range(0, 1)) : 1'b1;
      lif.load_valid = v; lif.load_sin = sin_tab[idx]; lif.load_cos = cos_tab[idx];
      if (idx == stop_idx) begin
        lif.load_valid = 1'b1; stop = 1'b1;
        break;
      end
      if (v && lif.load_ready) begin
        xfer_edges.push_back(cyc + 1);
        idx++;
      end
    end
    if (idx != stop_idx && idx < TABLE_DEPTH) begin
      checks++; errors++;
      $display("[TB] FAIL load_timeout: transfers %0d required %0d", idx, TABLE_DEPTH);
    end
  endtask

  task automatic finish_load();
    repeat (3) begin
      @(negedge clk); sample_cycle();
      lif.load_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({csb0, web0, wmask0, addr0, din00, din01, csb1, preload, pl_data, up_dn, delta,
         lif.load_ready, busy, running} !== RESET_VEC) begin
      errors++;
      $display("[TB] FAIL reset_values: got %h expected %h",
               {csb0, web0, wmask0, addr0, din00, din01, csb1, preload, pl_data, up_dn, delta,
                lif.load_ready, busy, running}, RESET_VEC);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({lif.load_ready, busy, running, csb0, csb1} !== 5'b00011) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got %b expected 00011",
               {lif.load_ready, busy, running, csb0, csb1});
    end
  endtask

  task automatic test_full_load();
    int e;
    cfg_phase0 = AW'($urandom); cfg_dir = bit'($urandom_range(0, 1));
    cfg_dstart = 4'd1; cfg_dmax = 4'd5; cfg_sweep = 1'b1; cfg_dwell = 16'd1000;
    do_start();
    run_load(1'b0, -1);
    finish_load();
    e = last_edge();
    run_edge = e + 1;
    checks++;
    if (xfer_edges.size() !== TABLE_DEPTH || wr_cyc.size() !== TABLE_DEPTH) begin
      errors++;
      $display("[TB] FAIL full_count: transfers %0d writes %0d required %0d",
               xfer_edges.size(), wr_cyc.size(), TABLE_DEPTH);
    end
    if (xfer_edges.size() == TABLE_DEPTH) begin
      checks++;
      if (xfer_edges[TABLE_DEPTH-1] - xfer_edges[0] !== TABLE_DEPTH - 1) begin
        errors++;
        $display("[TB] FAIL full_back_to_back: span %0d required %0d",
                 xfer_edges[TABLE_DEPTH-1] - xfer_edges[0], TABLE_DEPTH - 1);
      end
    end
    for (int i = 0; i < wr_cyc.size() && i < xfer_edges.size(); i++) begin
      checks++;
      if ({wr_addr[i], wr_sin[i], wr_cos[i], wr_mask[i], wr_cyc[i]} !==
          {AW'(i), sin_tab[i], cos_tab[i], 4'hF, xfer_edges[i]}) begin
        errors++;
        $display("[TB] FAIL full_write[%0d]: addr %0d sin %h cos %h mask %h cyc %0d required addr %0d sin %h cos %h mask f cyc %0d",
                 i, wr_addr[i], wr_sin[i], wr_cos[i], wr_mask[i], wr_cyc[i],
                 i, sin_tab[i], cos_tab[i], xfer_edges[i]);
      end
    end
    checks++;
    if (pre_cyc.size() !== 1) begin
      errors++;
      $display("[TB] FAIL preload_pulses: got %0d required 1", pre_cyc.size());
    end else begin
      checks++;
      if ({pre_cyc[0], pre_data[0], pre_updn[0], pre_delta[0]} !== {e, cfg_phase0, cfg_dir, cfg_dstart}) begin
        errors++;
        $display("[TB] FAIL preload_values: cyc %0d data %h up_dn %b delta %0d required cyc %0d data %h up_dn %b delta %0d",
                 pre_cyc[0], pre_data[0], pre_updn[0], pre_delta[0], e, cfg_phase0, cfg_dir, cfg_dstart);
      end
    end
    checks++;
    if (csb1_low_cyc !== e + 1) begin
      errors++;
      $display("[TB] FAIL csb1_timing: low at %0d required %0d", csb1_low_cyc, e + 1);
    end
    checks++;
    if ({running, busy, lif.load_ready} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL run_status: got %b required 100", {running, busy, lif.load_ready});
    end
  endtask

  task automatic test_sweep();
    int k, d;
    d = int'(cfg_dwell);
    k = cyc - run_edge;
    while (k <= 5 * d + 1) begin
      @(negedge clk);
      k = cyc - run_edge;
      if (k % d == 0 || k % d == d - 1) begin
        checks++;
        if ({running, delta} !== {1'b1, exp_delta(k)}) begin
          errors++;
          $display("[TB] FAIL sweep_delta k=%0d: running %b delta %0d required running 1 delta %0d",
                   k, running, delta, exp_delta(k));
        end
      end
    end
  endtask

  task automatic test_sweep_variants();
    int e, k;
    for (int v = 0; v < 3; v++) begin
      cfg_phase0 = AW'($urandom); cfg_dir = bit'($urandom_range(0, 1));
      cfg_dstart = DELTA_W'($urandom_range(0, 7));
      cfg_dmax   = DELTA_W'($urandom);
      cfg_sweep  = (v != 1);
      cfg_dwell  = (v == 2) ? 16'd0 : DWELL_W'($urandom_range(2, 6));
      if (v == 0) cfg_dmax = cfg_dstart + DELTA_W'($urandom_range(1, 8));
      do_stop();
      do_start();
      run_load(1'b0, -1);
      e = last_edge();
      for (int c = 0; c < 60; c++) begin
        @(negedge clk); sample_cycle();
        lif.load_valid = 1'b0;
        k = cyc - (e + 1);
        if (k >= 0) begin
          checks++;
          if (delta !== exp_delta(k)) begin
            errors++;
            $display("[TB] FAIL sweep_variant%0d k=%0d: delta %0d required %0d", v, k, delta, exp_delta(k));
          end
        end
      end
    end
  endtask

  task automatic test_throttled_load();
    int e;
    cfg_phase0 = AW'($urandom); cfg_dir = bit'($urandom_range(0, 1));
    cfg_dstart = DELTA_W'($urandom); cfg_dmax = DELTA_W'($urandom);
    cfg_sweep = 1'b0; cfg_dwell = 16'd4;
    do_stop();
    do_start();
    run_load(1'b1, -1);
    finish_load();
    e = last_edge();
    checks++;
    if (xfer_edges.size() !== TABLE_DEPTH || wr_cyc.size() !== TABLE_DEPTH) begin
      errors++;
      $display("[TB] FAIL throttle_count: transfers %0d writes %0d required %0d",
               xfer_edges.size(), wr_cyc.size(), TABLE_DEPTH);
    end
    for (int i = 0; i < wr_cyc.size() && i < xfer_edges.size(); i++) begin
      checks++;
      if ({wr_addr[i], wr_sin[i], wr_cos[i], wr_cyc[i]} !== {AW'(i), sin_tab[i], cos_tab[i], xfer_edges[i]}) begin
        errors++;
        $display("[TB] FAIL throttle_write[%0d]: addr %0d sin %h cos %h cyc %0d required addr %0d sin %h cos %h cyc %0d",
                 i, wr_addr[i], wr_sin[i], wr_cos[i], wr_cyc[i], i, sin_tab[i], cos_tab[i], xfer_edges[i]);
      end
    end
    checks++;
    if (pre_cyc.size() !== 1 || csb1_low_cyc !== e + 1) begin
      errors++;
      $display("[TB] FAIL throttle_prime: preload pulses %0d csb1 low at %0d required 1 pulse, csb1 low at %0d",
               pre_cyc.size(), csb1_low_cyc, e + 1);
    end
  endtask

  task automatic test_stop_restart();
    cfg_phase0 = AW'($urandom); cfg_dir = bit'($urandom_range(0, 1));
    cfg_dstart = DELTA_W'($urandom); cfg_dmax = DELTA_W'($urandom);
    cfg_sweep = 1'b0; cfg_dwell = 16'd0;
    do_stop();
    do_start();
    run_load(1'b0, 200);
    @(negedge clk); sample_cycle();
    stop = 1'b0; lif.load_valid = 1'b0;
    checks++;
    if ({lif.load_ready, busy, running, csb0, csb1} !== 5'b00011) begin
      errors++;
      $display("[TB] FAIL stop_idle: got %b required 00011", {lif.load_ready, busy, running, csb0, csb1});
    end
    checks++;
    if (wr_cyc.size() !== 200) begin
      errors++;
      $display("[TB] FAIL stop_partial_writes: got %0d required 200", wr_cyc.size());
    end
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checks++;
    if ({lif.load_ready, busy, running} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL start_stop_idle: got %b required 000", {lif.load_ready, busy, running});
    end
    do_start();
    run_load(1'b0, -1);
    finish_load();
    checks++;
    if (wr_cyc.size() !== TABLE_DEPTH || pre_cyc.size() !== 1) begin
      errors++;
      $display("[TB] FAIL restart_count: writes %0d preloads %0d required %0d and 1",
               wr_cyc.size(), pre_cyc.size(), TABLE_DEPTH);
    end
    if (wr_cyc.size() > 0) begin
      checks++;
      if ({wr_addr[0], wr_sin[0], wr_cos[0]} !== {{AW{1'b0}}, sin_tab[0], cos_tab[0]}) begin
        errors++;
        $display("[TB] FAIL restart_first: addr %0d sin %h cos %h required addr 0 sin %h cos %h",
                 wr_addr[0], wr_sin[0], wr_cos[0], sin_tab[0], cos_tab[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    cfg_phase0 = AW'($urandom) | AW'(1); cfg_dir = 1'b0;
    cfg_dstart = DELTA_W'($urandom_range(1, 15)); cfg_dmax = DELTA_W'($urandom);
    cfg_sweep = 1'b0; cfg_dwell = 16'd5;
    do_stop();
    do_start();
    run_load(1'b0, -1);
    finish_load();
    clear_log();
    @(negedge clk);
    start = 1'b1; phase0 = ~cfg_phase0; dir = 1'b1;
    @(negedge clk); sample_cycle();
    start = 1'b0;
    repeat (4) begin
      @(negedge clk); sample_cycle();
    end
    checks++;
    if ({running, busy, lif.load_ready, pl_data, up_dn} !== {3'b100, cfg_phase0, cfg_dir}) begin
      errors++;
      $display("[TB] FAIL start_in_run: status %b pl_data %h up_dn %b required 100 %h %b",
               {running, busy, lif.load_ready}, pl_data, up_dn, cfg_phase0, cfg_dir);
    end
    checks++;
    if (wr_cyc.size() + pre_cyc.size() !== 0) begin
      errors++;
      $display("[TB] FAIL start_in_run_activity: writes %0d preloads %0d required 0 and 0",
               wr_cyc.size(), pre_cyc.size());
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({csb0, web0, wmask0, addr0, din00, din01, csb1, preload, pl_data, up_dn, delta,
         lif.load_ready, busy, running} !== RESET_VEC) begin
      errors++;
      $display("[TB] FAIL async_reset_values: got %h expected %h",
               {csb0, web0, wmask0, addr0, din00, din01, csb1, preload, pl_data, up_dn, delta,
                lif.load_ready, busy, running}, RESET_VEC);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({lif.load_ready, busy, running, csb1} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL idle_after_async_reset: got %b required 0001",
               {lif.load_ready, busy, running, csb1});
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    lif.load_valid = 1'b0; lif.load_sin = '0; lif.load_cos = '0;
    phase0 = '0; dir = 1'b0; delta_start = '0; delta_max = '0; sweep_en = 1'b0; dwell = '0;
    csb1_low_cyc = -1; run_edge = 0;
    fill_tables();
    test_reset();
    test_full_load();
    test_sweep();
    test_sweep_variants();
    test_throttled_load();
    test_stop_restart();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
